// File: rtl/vibrometer_pkg.sv
// Shared encodings for the synthetic fringe source: controller states, quadrature phases,
// the phase-to-channel-level table and the log-scale clamp.
package vibrometer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MOVE = 1'b1
  } fg_state_e;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_0     = 2'd0;
  localparam phase_t PH_1     = 2'd1;
  localparam phase_t PH_2     = 2'd2;
  localparam phase_t PH_3     = 2'd3;
  localparam phase_t PH_RESET = PH_3;

  localparam logic [4:0] LOG_SCALE_MAX = 5'd15;

  // Returns {b_high, a_high}; one fringe is 0:(H,L) 1:(H,H) 2:(L,H) 3:(L,L) in (a,b) order.
  function automatic logic [1:0] phase_levels(input phase_t ph);
    case (ph)
      PH_0:    return 2'b01;
      PH_1:    return 2'b11;
      PH_2:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/fringe_phase_sequencer.sv
// Quadrature phase register with per-phase dwell counting over accepted output beats.
// Flags the a-falling transitions that move the emitted position by one step.
module fringe_phase_sequencer
  import vibrometer_pkg::*;
#(
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   aclk_i,
  input  logic                   aresetn_i,
  input  logic                   run_i,
  input  logic                   start_i,
  input  logic                   beat_i,
  input  logic                   fwd_i,
  input  logic [DWELL_WIDTH-1:0] dwell_i,
  output phase_t                 phase_o,
  output logic                   advance_o,
  output logic                   pos_inc_o,
  output logic                   pos_dec_o
);

  phase_t                 phase_q, phase_d;
  logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_WIDTH:0]   dwell_eff;
  logic [DWELL_WIDTH:0]   cnt_next;

  always_comb begin
    dwell_eff   = (dwell_i == '0) ? {{DWELL_WIDTH{1'b0}}, 1'b1} : {1'b0, dwell_i};
    cnt_next    = {1'b0, dwell_cnt_q} + {{DWELL_WIDTH{1'b0}}, 1'b1};
    advance_o   = run_i & beat_i & (cnt_next == dwell_eff);
    dwell_cnt_d = dwell_cnt_q;
    phase_d     = phase_q;
    if (start_i) begin
      dwell_cnt_d = '0;
    end else if (advance_o) begin
      dwell_cnt_d = '0;
      phase_d     = fwd_i ? phase_q + 2'd1 : phase_q - 2'd1;
    end else if (run_i & beat_i) begin
      dwell_cnt_d = cnt_next[DWELL_WIDTH-1:0];
    end
    // a falls with b high going forward, with b low going in reverse
    pos_inc_o = advance_o & fwd_i & (phase_q == PH_1);
    pos_dec_o = advance_o & ~fwd_i & (phase_q == PH_0);
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      phase_q     <= PH_RESET;
      dwell_cnt_q <= '0;
    end else begin
      phase_q     <= phase_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/axis_fringe_generator.sv
// Synthetic interferometer fringe source: walks its emitted position toward an AXIS target in
// whole steps of 2^log_scale, emitting {signal_b, signal_a} quadrature samples on an AXIS master.
module axis_fringe_generator
  import vibrometer_pkg::*;
#(
  parameter int S_AXIS_TDATA_WIDTH = 16,
  parameter int M_AXIS_TDATA_WIDTH = 32,
  parameter int DWELL_WIDTH        = 16
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [M_AXIS_TDATA_WIDTH/2-1:0] FG_high_level,
  input  logic [M_AXIS_TDATA_WIDTH/2-1:0] FG_low_level,
  input  logic [4:0]                      FG_log_scale,
  input  logic [DWELL_WIDTH-1:0]          FG_dwell,
  output logic [S_AXIS_TDATA_WIDTH-1:0]   FG_position,
  output logic                            FG_busy,
  input  logic                            S_AXIS_tvalid,
  input  logic [S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_tdata,
  output logic                            S_AXIS_tready,
  input  logic                            M_AXIS_tready,
  output logic                            M_AXIS_tvalid,
  output logic [M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_tdata
);

  localparam int S = S_AXIS_TDATA_WIDTH;

  fg_state_e   state_q, state_d;
  logic [S-1:0] target_q, target_d;
  logic [S-1:0] position_q, position_d;
  logic         tvalid_q;

  logic [3:0]   log_clamped;
  logic [S:0]   step;
  logic         s_hs, m_beat, run, start, fwd;
  logic         advance, pos_inc, pos_dec;
  phase_t       phase;
  logic [1:0]   levels;

  // Distance in S+1 bits so opposite-sign operands never wrap.
  function automatic logic [S:0] abs_diff(input logic [S-1:0] a, input logic [S-1:0] b);
    logic [S:0] d;
    d = {a[S-1], a} - {b[S-1], b};
    return d[S] ? -d : d;
  endfunction

  assign log_clamped   = (FG_log_scale > LOG_SCALE_MAX) ? LOG_SCALE_MAX[3:0] : FG_log_scale[3:0];
  assign step          = {{S{1'b0}}, 1'b1} << log_clamped;
  assign S_AXIS_tready = (state_q == ST_IDLE);
  assign s_hs          = S_AXIS_tvalid & S_AXIS_tready;
  assign M_AXIS_tvalid = tvalid_q;
  assign m_beat        = M_AXIS_tvalid & M_AXIS_tready;
  assign run           = (state_q == ST_MOVE);
  assign fwd           = ($signed(target_q) >= $signed(position_q));

  fringe_phase_sequencer #(
    .DWELL_WIDTH(DWELL_WIDTH)
  ) u_seq (
    .aclk_i    (aclk),
    .aresetn_i (aresetn),
    .run_i     (run),
    .start_i   (start),
    .beat_i    (m_beat),
    .fwd_i     (fwd),
    .dwell_i   (FG_dwell),
    .phase_o   (phase),
    .advance_o (advance),
    .pos_inc_o (pos_inc),
    .pos_dec_o (pos_dec)
  );

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    position_d = position_q;
    start      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_hs) begin
          target_d = S_AXIS_tdata;
          if (abs_diff(S_AXIS_tdata, position_q) >= step) begin
            state_d = ST_MOVE;
            start   = 1'b1;
          end
        end
      end
      ST_MOVE: begin
        if (advance && (pos_inc || pos_dec)) begin
          position_d = pos_inc ? position_q + step[S-1:0] : position_q - step[S-1:0];
          if (abs_diff(target_q, position_d) < step) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      target_q   <= '0;
      position_q <= '0;
      tvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      position_q <= position_d;
      tvalid_q   <= 1'b1;
    end
  end

  assign levels       = phase_levels(phase);
  assign M_AXIS_tdata = {levels[1] ? FG_high_level : FG_low_level,
                         levels[0] ? FG_high_level : FG_low_level};
  assign FG_position  = position_q;
  assign FG_busy      = run;

endmodule
